byte_lane_ram: RTL and testbench
================================

Name: byte_lane_ram

Overview:
Parametrised single-port synchronous RAM with per-byte write enables, registered read with a valid strobe, and a hardware clear sequencer. It replaces fixed-width memories built from hand-instanced 8-bit slices and serves as the general data/register store in the lab datapath. After reset or on request, a sweep FSM zeroes the array one word per cycle, so no async reset of the storage is required.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8 (NB = DATA_W/8 byte lanes).
ADDR_W, 5, address width.
DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_W.

Ports:
clock  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
data_in  input  DATA_W  write data.
address  input  ADDR_W  word address for the read or write.
byte_en  input  NB  per-lane write enable; bit i covers data_in[8i+7:8i].
write_en  input  1  write request, sampled on the clock edge.
read_en  input  1  read request, sampled on the clock edge.
clear_req  input  1  request a full-array clear.
data_out  output  DATA_W  registered read data.
read_valid  output  1  one-cycle strobe: data_out was updated by the previous read.
addr_err  output  1  one-cycle strobe: the previous access used address >= DEPTH.
busy  output  1  high while clearing; accesses are ignored.

Behaviour:
- Reset (reset=0, async): data_out=0, read_valid=0, addr_err=0, busy=1, state=CLEAR, clr_ptr=0. Array contents are not reset directly; the sweep zeroes them.
- FSM has two states, CLEAR and IDLE.
- CLEAR: each cycle writes mem[clr_ptr]=0 and increments clr_ptr. When clr_ptr==DEPTH-1 is written, next state=IDLE and busy=0 from that edge. Sweep takes exactly DEPTH cycles after reset deassertion or clear acceptance.
- CLEAR ignores write_en, read_en and clear_req. read_valid=0, addr_err=0, data_out holds.
- IDLE with clear_req=1: next state=CLEAR, clr_ptr=0, busy=1 next cycle. clear_req has priority; a same-cycle read/write is dropped and no strobes are produced.
- IDLE write (write_en=1, address<DEPTH): for each i with byte_en[i]=1, mem[address] lane i <= data_in lane i. Other lanes unchanged. byte_en=0 is a legal no-op.
- IDLE read (read_en=1, address<DEPTH): data_out <= mem[address] at the edge. read_valid=1 for exactly the following cycle. Latency is 1 cycle.
- data_out holds its last value when no read occurs.
- Read and write to the same address in the same cycle: read-before-write. data_out returns the old word; new bytes are visible to reads from the next cycle.
- Address >= DEPTH (only possible when DEPTH < 2**ADDR_W): the write is ignored. A read loads data_out=0 with read_valid=1. addr_err=1 for one cycle if either read_en or write_en is set.
- Reset asserted mid-sweep or mid-access: immediate return to reset values. The sweep restarts from 0 after release.
- Back-to-back reads every cycle are supported: read_valid stays high continuously.

Test Plan:
- Reset release, DEPTH=32 -> busy=1 for exactly 32 cycles, then 0. A read of every address returns 0x00000000 with read_valid=1 one cycle after each read_en.
- Write 0xDEADBEEF to addr 5 with byte_en=4'b1111, then write 0x11223344 to addr 5 with byte_en=4'b0101 -> read addr 5 returns 0xDE22BE44.
- Same-cycle write 0xCAFEF00D and read at addr 7 (previously 0x00000001) -> data_out=0x00000001. Read next cycle -> 0xCAFEF00D.
- DEPTH=20, ADDR_W=5: write 0xFFFFFFFF to addr 25 then read addr 25 -> addr_err pulses twice, data_out=0, read_valid=1. Addr 19 is unaffected.
- After data written, pulse clear_req together with write_en to addr 3 -> write dropped, busy=1 for 32 cycles. All reads return 0. read_en during busy yields no read_valid.
- Assert reset at sweep cycle 10, release -> busy lasts a full 32 cycles. data_out=0 and read_valid=0 during reset.

Source files
------------

// File: rtl/byte_lane_ram_if.sv
// Bus bundle for byte_lane_ram: access request side plus registered read/status returns.
// The master drives requests; the RAM (slave) drives data_out and the status strobes.
interface byte_lane_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] address;
    logic [NB-1:0]     byte_en;
    logic              write_en;
    logic              read_en;
    logic              clear_req;
    logic [DATA_W-1:0] data_out;
    logic              read_valid;
    logic              addr_err;
    logic              busy;

    modport master (
        output data_in,
        output address,
        output byte_en,
        output write_en,
        output read_en,
        output clear_req,
        input  data_out,
        input  read_valid,
        input  addr_err,
        input  busy
    );

    modport slave (
        input  data_in,
        input  address,
        input  byte_en,
        input  write_en,
        input  read_en,
        input  clear_req,
        output data_out,
        output read_valid,
        output addr_err,
        output busy
    );
endinterface

// File: rtl/byte_lane_ram.sv
// Single-port RAM with per-byte write enables, registered read + valid strobe and a
// clear sequencer that zeroes one word per cycle after reset or on clear_req.
module byte_lane_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    byte_lane_ram_if.slave    bus
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    generate
        if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_width
            $error("byte_lane_ram: DATA_W must be a positive multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
            $error("byte_lane_ram: DEPTH must be in 1 .. 2**ADDR_W");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                read_valid_q;
    logic                addr_err_q;
    logic                busy_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic                mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic [NB-1:0]       mem_be_d;

    // Address range decode and old-word fetch (read-before-write on a shared address).
    always_comb begin
        in_range_s = ({1'b0, bus.address} < DEPTH_C);
        rd_word_s  = '0;
        if (in_range_s) begin
            rd_word_s = mem_q[bus.address];
        end else begin
            rd_word_s = '0;
        end
    end

    // Storage port arbitration: the sweep owns the array while clearing.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = clr_ptr_q;
        mem_wdata_d = '0;
        mem_be_d    = '1;
        if (state_q == ST_CLEAR) begin
            mem_we_d = 1'b1;
        end else if (!bus.clear_req && bus.write_en && in_range_s) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.address;
            mem_wdata_d = bus.data_in;
            mem_be_d    = bus.byte_en;
        end else begin
            mem_we_d = 1'b0;
        end
    end

    // Array write port; no reset because the sweep initialises the contents.
    always_ff @(posedge clock) begin
        if (mem_we_d) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be_d[i]) begin
                    mem_q[mem_addr_d][8*i +: 8] <= mem_wdata_d[8*i +: 8];
                end
            end
        end
    end

    // Clear/idle sequencer with registered read data and status strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            data_out_q   <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    read_valid_q <= 1'b0;
                    addr_err_q   <= 1'b0;
                    if (clr_ptr_q == LAST_C) begin
                        state_q   <= ST_IDLE;
                        clr_ptr_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        state_q      <= ST_CLEAR;
                        clr_ptr_q    <= '0;
                        busy_q       <= 1'b1;
                        read_valid_q <= 1'b0;
                        addr_err_q   <= 1'b0;
                    end else begin
                        busy_q       <= 1'b0;
                        read_valid_q <= bus.read_en;
                        addr_err_q   <= (bus.read_en || bus.write_en) && !in_range_s;
                        if (bus.read_en) begin
                            data_out_q <= rd_word_s;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_CLEAR;
                    clr_ptr_q    <= '0;
                    busy_q       <= 1'b1;
                    read_valid_q <= 1'b0;
                    addr_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.read_valid = read_valid_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_byte_lane_ram.sv
// Randomised bench for byte_lane_ram: two instances (DEPTH 32 and DEPTH 20) share stimulus
// and are checked every cycle against a word-array model, plus literal pins from the test plan.
module tb_byte_lane_ram;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_addr = '0;
    logic [3:0]    in_be   = '0;
    logic          in_we   = 1'b0;
    logic          in_re   = 1'b0;
    logic          in_clr  = 1'b0;

    byte_lane_ram_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    byte_lane_ram_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.data_in = in_data;  assign if1.data_in = in_data;
    assign if0.address = in_addr;  assign if1.address = in_addr;
    assign if0.byte_en = in_be;    assign if1.byte_en = in_be;
    assign if0.write_en = in_we;   assign if1.write_en = in_we;
    assign if0.read_en = in_re;    assign if1.read_en = in_re;
    assign if0.clear_req = in_clr; assign if1.clear_req = in_clr;

    byte_lane_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32)) dut0 (
        .clock (clock), .reset (reset), .bus (if0.slave));
    byte_lane_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20)) dut1 (
        .clock (clock), .reset (reset), .bus (if1.slave));

    logic [DW-1:0] act_dout [2];
    logic          act_rv   [2];
    logic          act_ae   [2];
    logic          act_busy [2];
    assign act_dout[0] = if0.data_out;   assign act_dout[1] = if1.data_out;
    assign act_rv[0]   = if0.read_valid; assign act_rv[1]   = if1.read_valid;
    assign act_ae[0]   = if0.addr_err;   assign act_ae[1]   = if1.addr_err;
    assign act_busy[0] = if0.busy;       assign act_busy[1] = if1.busy;

    int n_cmp = 0;
    int n_err = 0;

    function automatic int dep(input int k);
        return (k == 0) ? 32 : 20;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[inst%0d] at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Reference model: a plain word array per instance; a clear wipes it at once and the
    // instance then stays busy for DEPTH edges.
    logic [DW-1:0] m_mem  [2][32];
    int            m_clr  [2];
    logic [DW-1:0] m_dout [2];
    logic          m_rv   [2];
    logic          m_ae   [2];

    always @(posedge clock or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_clr[k]  <= dep(k);
                m_dout[k] <= '0;
                m_rv[k]   <= 1'b0;
                m_ae[k]   <= 1'b0;
                for (int a = 0; a < 32; a++) m_mem[k][a] <= '0;
            end else if (m_clr[k] > 0) begin
                m_clr[k] <= m_clr[k] - 1;
                m_rv[k]  <= 1'b0;
                m_ae[k]  <= 1'b0;
            end else if (in_clr) begin
                m_clr[k] <= dep(k);
                m_rv[k]  <= 1'b0;
                m_ae[k]  <= 1'b0;
                for (int a = 0; a < 32; a++) m_mem[k][a] <= '0;
            end else begin
                m_rv[k] <= in_re;
                m_ae[k] <= (in_re || in_we) && (int'(in_addr) >= dep(k));
                if (in_re) m_dout[k] <= (int'(in_addr) < dep(k)) ? m_mem[k][in_addr] : '0;
                if (in_we && int'(in_addr) < dep(k)) begin
                    for (int b = 0; b < 4; b++)
                        if (in_be[b]) m_mem[k][in_addr][8*b +: 8] <= in_data[8*b +: 8];
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            check("data_out",   k, act_dout[k], m_dout[k]);
            check("read_valid", k, 32'(act_rv[k]), 32'(m_rv[k]));
            check("addr_err",   k, 32'(act_ae[k]), 32'(m_ae[k]));
            check("busy",       k, 32'(act_busy[k]), 32'(m_clr[k] > 0));
        end
    end

    task automatic cyc(input logic we, input logic re, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [DW-1:0] d, input logic clr);
        in_we = we; in_re = re; in_addr = a; in_be = be; in_data = d; in_clr = clr;
        @(negedge clock);
    endtask

    task automatic run_until_idle(output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        for (int c = 1; c <= 100; c++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), 4'hF, 32'h0, 1'b0);
            if (n0 == 0 && !act_busy[0]) n0 = c;
            if (n1 == 0 && !act_busy[1]) n1 = c;
            if (n0 != 0 && n1 != 0) break;
        end
    endtask

    int b0, b1;

    initial begin
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check("rst_dout", k, act_dout[k], 32'h0);
            check("rst_rv",   k, 32'(act_rv[k]), 32'h0);
            check("rst_busy", k, 32'(act_busy[k]), 32'h1);
        end
        #1 reset = 1'b1;
        run_until_idle(b0, b1);
        check("busy_len_reset", 0, 32'(b0), 32'd32);
        check("busy_len_reset", 1, 32'(b1), 32'd20);

        // Every address reads back zero after the sweep.
        for (int a = 0; a < 32; a++) begin
            cyc(1'b0, 1'b1, AW'(a), 4'h0, 32'h0, 1'b0);
            check("sweep_zero", 0, act_dout[0], 32'h0);
            check("sweep_rv",   0, 32'(act_rv[0]), 32'h1);
        end

        // Byte-lane merge.
        cyc(1'b1, 1'b0, 5'd5, 4'hF,    32'hDEADBEEF, 1'b0);
        cyc(1'b1, 1'b0, 5'd5, 4'b0101, 32'h11223344, 1'b0);
        cyc(1'b0, 1'b1, 5'd5, 4'h0,    32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            check("lane_merge",       k, act_dout[k], 32'hDE22BE44);
            check("model_lane_merge", k, m_dout[k],   32'hDE22BE44);
        end

        // Read-before-write on the same address.
        cyc(1'b1, 1'b0, 5'd7, 4'hF, 32'h00000001, 1'b0);
        cyc(1'b1, 1'b1, 5'd7, 4'hF, 32'hCAFEF00D, 1'b0);
        for (int k = 0; k < 2; k++) check("rbw_old", k, act_dout[k], 32'h00000001);
        cyc(1'b0, 1'b1, 5'd7, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) check("rbw_new", k, act_dout[k], 32'hCAFEF00D);

        // Out-of-range access on the DEPTH=20 instance.
        cyc(1'b1, 1'b0, 5'd19, 4'hF, 32'h5A5A5A5A, 1'b0);
        cyc(1'b1, 1'b0, 5'd25, 4'hF, 32'hFFFFFFFF, 1'b0);
        check("oor_wr_err", 1, 32'(act_ae[1]), 32'h1);
        check("inr_wr_err", 0, 32'(act_ae[0]), 32'h0);
        cyc(1'b0, 1'b1, 5'd25, 4'h0, 32'h0, 1'b0);
        check("oor_rd_err",  1, 32'(act_ae[1]), 32'h1);
        check("oor_rd_rv",   1, 32'(act_rv[1]), 32'h1);
        check("oor_rd_dout", 1, act_dout[1], 32'h0);
        check("inr_rd_dout", 0, act_dout[0], 32'hFFFFFFFF);
        cyc(1'b0, 1'b1, 5'd19, 4'h0, 32'h0, 1'b0);
        check("addr19_kept", 1, act_dout[1], 32'h5A5A5A5A);
        check("addr19_err",  1, 32'(act_ae[1]), 32'h0);

        // Clear request beats a same-cycle write.
        cyc(1'b1, 1'b0, 5'd3, 4'hF, 32'h12345678, 1'b0);
        cyc(1'b1, 1'b0, 5'd3, 4'hF, 32'hAAAAAAAA, 1'b1);
        for (int k = 0; k < 2; k++) check("clr_busy", k, 32'(act_busy[k]), 32'h1);
        run_until_idle(b0, b1);
        check("busy_len_clr", 0, 32'(b0), 32'd32);
        check("busy_len_clr", 1, 32'(b1), 32'd20);
        cyc(1'b0, 1'b1, 5'd3, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) check("clr_zero3", k, act_dout[k], 32'h0);
        cyc(1'b0, 1'b1, 5'd5, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) check("clr_zero5", k, act_dout[k], 32'h0);

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                4'($urandom_range(0, 15)), 32'($urandom), 1'($urandom_range(0, 99) == 0));
        end

        // Reset in the middle of a sweep restarts it from the beginning.
        run_until_idle(b0, b1);
        cyc(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b1);
        repeat (10) cyc(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0);
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("midrst_dout", k, act_dout[k], 32'h0);
            check("midrst_rv",   k, 32'(act_rv[k]), 32'h0);
            check("midrst_busy", k, 32'(act_busy[k]), 32'h1);
        end
        @(negedge clock);
        #1 reset = 1'b1;
        run_until_idle(b0, b1);
        check("busy_len_midrst", 0, 32'(b0), 32'd32);
        check("busy_len_midrst", 1, 32'(b1), 32'd20);

        cyc(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
